// File: rtl/reg_mem_fifo_ctrl.sv
// FIFO controller built on a single-port reg_mem: byte stream in, ordered stream out
// through a one-entry output register. Reads take priority over writes on the shared port.
module reg_mem_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_BITS:0]    level
);

    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(2**ADDR_BITS);

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  rd_req;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0) && !out_valid_q;
    assign level     = count_q + (ADDR_BITS+1)'(out_valid_q);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign rd_req    = (state_q == IDLE) && !out_valid_q && (count_q != '0);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mem_addr    = wr_ptr_q;
        mem_wdata   = in_data;
        mem_wen     = 1'b0;
        in_ready    = 1'b0;

        // A pop never coincides with a capture: RD is only entered while out_valid is low.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    mem_addr = rd_ptr_q;
                    state_d  = RD;
                end else begin
                    in_ready = !full && !rst;
                    mem_wen  = in_valid && in_ready;
                    if (mem_wen) begin
                        wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
                        count_d  = count_q + (ADDR_BITS+1)'(1);
                    end
                end
            end
            RD: begin
                // Address held a second cycle so registered-read memories also deliver here.
                mem_addr    = rd_ptr_q;
                out_data_d  = mem_rdata;
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + ADDR_BITS'(1);
                count_d     = count_q - (ADDR_BITS+1)'(1);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/reg_mem_fifo_ctrl.md
Name: reg_mem_fifo_ctrl

Overview:
- Upstream controller that turns the single-port reg_mem array into a first-in-first-out (FIFO) queue.
- Accepts a valid/ready byte stream and writes it to reg_mem at a wrapping write pointer.
- Reads entries back in order through the same port into a one-entry output register, presented as a valid/ready stream.
- Drives reg_mem's addr, data_in and wen and consumes its data_out; one memory access per cycle, with reads taking priority.

Parameters:
DATA_WIDTH, 8, width of stored words; must match the reg_mem instance.
ADDR_BITS, 5, reg_mem address width; DEPTH = 2**ADDR_BITS = 32 entries.

Ports:
clk  input  1  rising-edge clock, shared with reg_mem
rst  input  1  synchronous active-high reset
in_data  input  DATA_WIDTH  write word
in_valid  input  1  in_data valid
in_ready  output  1  word accepted on a clk edge when in_valid&&in_ready
out_data  output  DATA_WIDTH  head-of-queue word
out_valid  output  1  out_data valid
out_ready  input  1  consumer takes out_data when out_valid&&out_ready
mem_addr  output  ADDR_BITS  to reg_mem addr
mem_wdata  output  DATA_WIDTH  to reg_mem data_in
mem_wen  output  1  to reg_mem wen
mem_rdata  input  DATA_WIDTH  from reg_mem data_out
full  output  1  count==DEPTH
empty  output  1  count==0 && !out_valid
level  output  ADDR_BITS+1  count+out_valid, range 0..DEPTH+1

Behaviour:
- Internal registers: wr_ptr, rd_ptr (ADDR_BITS each, wrap modulo DEPTH); count (ADDR_BITS+1, words in memory, 0..DEPTH); state in {IDLE, RD}; out_data; out_valid.
- Reset (rst high at a clk edge):
  - Pointers, count, out_valid and out_data go to 0; state goes to IDLE.
  - While rst is high: in_ready=0, mem_wen=0.
  - Memory contents are not cleared and are ignored afterwards.
- Read request: rd_req = (state==IDLE) && !out_valid && count!=0.
- IDLE with rd_req:
  - mem_addr=rd_ptr, mem_wen=0, in_ready=0; next state RD.
- IDLE without rd_req:
  - mem_addr=wr_ptr, mem_wdata=in_data, in_ready=!full, mem_wen=in_valid&&in_ready.
  - On write: wr_ptr+1, count+1.
- RD:
  - mem_addr held at rd_ptr, mem_wen=0, in_ready=0.
  - At the end of the cycle: out_data<=mem_rdata, out_valid<=1, rd_ptr+1, count-1, state IDLE.
  - Holding the address for two cycles makes the capture correct for both combinational and 1-cycle registered reg_mem reads.
- Output handshake:
  - out_valid drops on out_valid&&out_ready unless reloaded in the same edge. Reload cannot occur that edge, since RD is entered only with out_valid=0.
  - out_data is stable while out_valid&&!out_ready.
- Latency: word accepted in cycle 0 into an empty FIFO -> rd_req in cycle 1, RD in cycle 2, out_valid=1 in cycle 3.
- Capacity: DEPTH words in memory plus 1 in the output register = DEPTH+1.
  - When full=1, in_ready=0; in_valid is held without loss.
- Simultaneous events:
  - A pop and a write in the same cycle are both honoured.
  - A pop in cycle N makes rd_req visible in cycle N+1, which blocks writes for 2 cycles (IDLE decision + RD).
- Pointer wrap: 31 -> 0 with no special handling; order is preserved across the wrap.
- rst during RD: the read is aborted, no capture occurs, and the block returns to IDLE empty.
- All outputs are combinational from registered state except in_ready/mem_wen/mem_wdata, which also depend on in_valid/in_data.

Test Plan:
- Basic path, reset then push 0xA5 once: mem_wen=1, addr 0 in the accept cycle; mem_addr=0 with wen=0 for the next 2 cycles; out_data=0xA5, out_valid=1 in cycle 3; level=1, empty=0.
- Fill, out_ready=0, push 128..160 continuously:
  - Exactly 33 words accepted.
  - full=1, level=33, in_ready=0.
  - Word 161 is held and not written.
- Drain after fill, out_ready=1: out_data sequence 128..160 in order; empty=1 and level=0 at the end.
- Wrap and backpressure: push 100 words, value i+10, with in_valid and out_ready each toggled pseudo-randomly. All 100 words come out in order, pointers pass 31->0 at least 3 times, and level never exceeds 33.
- Simultaneous: with level=5 and out_valid=1, assert out_ready and push in the same cycle. The pop completes and the write lands at wr_ptr; the next cycle is a read (in_ready=0 for 2 cycles); level stays 5.
- Reset mid-operation: rst during RD with level=10. Next cycle level=0, out_valid=0, in_ready=1. A subsequent push of 0x3C reads back 0x3C, not stale data.
